// File: rtl/pwm_mch.sv
// pwm_mch: multi-channel PWM generator with edge/center-aligned counting,
// per-channel output polarity and shadowed duty updates at the period boundary.
module pwm_mch #(
  parameter int unsigned NCH = 2,
  parameter int unsigned DW  = 7,
  parameter int unsigned PSW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PSW-1:0] prescale,
  input  logic           mode,
  input  logic [NCH-1:0] wr_en,
  input  logic           wr_ena,
  input  logic [DW-1:0]  wr_duty,
  input  logic [NCH-1:0] pol,
  output logic [NCH-1:0] pwm_o,
  output logic           period_end,
  output logic [NCH-1:0] upd_pend
);

  localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  logic [PSW-1:0] r_pcnt;
  logic [DW-1:0]  r_cnt;
  logic [DW-1:0]  w_cnt_nxt;
  dir_t           r_dir;
  dir_t           w_dir_nxt;
  logic           r_mode;
  logic           w_mode_nxt;
  logic           w_tick;
  logic           w_bnd;
  logic           r_bnd;
  logic [NCH-1:0] r_ena;
  logic [DW-1:0]  r_duty_act [NCH];
  logic [DW-1:0]  r_duty_sh  [NCH];

  assign w_tick = (r_pcnt == prescale);

  // Prescaler, counter, direction and latched mode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_UP;
      r_mode <= 1'b0;
      r_bnd  <= 1'b0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PSW'(1);
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_mode <= w_mode_nxt;
      r_bnd  <= w_bnd;
    end
  end

  // Counter sequencing; center mode holds one tick at each end while dir flips
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_mode_nxt = r_mode;
    w_bnd      = 1'b0;
    if (w_tick) begin
      if (!r_mode) begin
        w_cnt_nxt = r_cnt + DW'(1);
        w_bnd     = (r_cnt == CNT_MAX);
      end else begin
        case (r_dir)
          DIR_UP: begin
            if (r_cnt == CNT_MAX) w_dir_nxt = DIR_DN;
            else                  w_cnt_nxt = r_cnt + DW'(1);
          end
          DIR_DN: begin
            if (r_cnt == '0) w_bnd     = 1'b1;
            else             w_cnt_nxt = r_cnt - DW'(1);
          end
          default: w_dir_nxt = DIR_UP;
        endcase
      end
      if (w_bnd) begin
        w_cnt_nxt  = '0;
        w_dir_nxt  = DIR_UP;
        w_mode_nxt = mode;
      end
    end
  end

  // Delayed once more so period_end coincides with the first output of the new period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_end <= 1'b0;
    else     period_end <= r_bnd;
  end

  // Per-channel enable, shadow/active duty and output flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena    <= '0;
      upd_pend <= '0;
      pwm_o    <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        r_duty_act[i] <= '0;
        r_duty_sh[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (wr_en[i]) begin
          r_ena[i]     <= wr_ena;
          r_duty_sh[i] <= wr_duty;
          if ((wr_ena && !r_ena[i]) || w_bnd) begin
            r_duty_act[i] <= wr_duty;
            upd_pend[i]   <= 1'b0;
          end else begin
            upd_pend[i]   <= 1'b1;
          end
        end else if (w_bnd) begin
          r_duty_act[i] <= r_duty_sh[i];
          upd_pend[i]   <= 1'b0;
        end
        pwm_o[i] <= r_ena[i] ? ((r_cnt < r_duty_act[i]) ^ pol[i]) : pol[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_mch.sv
// Self-checking bench for pwm_mch: directed scenario tasks plus a randomized
// run checked against a phase-arithmetic reference model.
module tb_pwm_mch;

  localparam int NCH = 2;
  localparam int DW  = 7;
  localparam int PSW = 8;
  localparam int M   = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [PSW-1:0] prescale;
  logic           mode;
  logic [NCH-1:0] wr_en;
  logic           wr_ena;
  logic [DW-1:0]  wr_duty;
  logic [NCH-1:0] pol;
  logic [NCH-1:0] pwm_o;
  logic           period_end;
  logic [NCH-1:0] upd_pend;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_mch #(.NCH(NCH), .DW(DW), .PSW(PSW)) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .mode(mode),
    .wr_en(wr_en), .wr_ena(wr_ena), .wr_duty(wr_duty), .pol(pol),
    .pwm_o(pwm_o), .period_end(period_end), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  // Reference model: position in the period is a clock count; cnt is derived from it
  int             m_ph;
  logic           m_mode;
  logic           m_bnd_d;
  logic [NCH-1:0] m_ena;
  logic [NCH-1:0] m_pend;
  logic [DW-1:0]  m_duty [NCH];
  logic [DW-1:0]  m_sh   [NCH];
  logic [NCH-1:0] exp_pwm;
  logic [NCH-1:0] exp_pend;
  logic           exp_pe;
  int             mp1, mlc, mk, mc;
  bit             mbnd;

  function automatic int lc_now();
    return (m_mode ? 2 * M : M) * (int'(prescale) + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_mode = 1'b0; m_bnd_d = 1'b0; m_ena = '0; m_pend = '0;
      for (int i = 0; i < NCH; i++) begin m_duty[i] = '0; m_sh[i] = '0; end
      exp_pwm = '0; exp_pe = 1'b0; exp_pend = '0;
    end else begin
      mp1  = int'(prescale) + 1;
      mlc  = lc_now();
      mk   = m_ph / mp1;
      mc   = (m_mode && mk >= M) ? (2 * M - 1 - mk) : mk;
      mbnd = (m_ph == mlc - 1);
      for (int i = 0; i < NCH; i++)
        exp_pwm[i] = m_ena[i] ? ((mc < int'(m_duty[i])) ^ pol[i]) : pol[i];
      exp_pe = m_bnd_d;
      for (int i = 0; i < NCH; i++) begin
        if (wr_en[i]) begin
          if ((wr_ena && !m_ena[i]) || mbnd) begin m_duty[i] = wr_duty; m_pend[i] = 1'b0; end
          else m_pend[i] = 1'b1;
          m_sh[i]  = wr_duty;
          m_ena[i] = wr_ena;
        end else if (mbnd) begin
          m_duty[i] = m_sh[i]; m_pend[i] = 1'b0;
        end
      end
      exp_pend = m_pend;
      m_bnd_d  = mbnd;
      if (mbnd) begin m_ph = 0; m_mode = mode; end
      else m_ph = m_ph + 1;
    end
  end

  task automatic do_reset(input int ps, input logic md);
    rst = 1'b1; wr_en = '0; prescale = PSW'(ps); mode = md;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [NCH-1:0] ch, input logic ena, input logic [DW-1:0] d);
    wr_en = ch; wr_ena = ena; wr_duty = d;
    @(negedge clk);
    wr_en = '0;
  endtask

  task automatic wait_pe(output bit ok);
    int n = 0;
    while (period_end !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    ok = (period_end === 1'b1);
  endtask

  // Counts cycles and high cycles up to (not including) the next period_end
  task automatic measure(output int len, output int h0, output int h1, output bit ok);
    len = 0; h0 = 0; h1 = 0;
    do begin
      h0 += int'(pwm_o[0]); h1 += int'(pwm_o[1]); len++;
      @(negedge clk);
    end while (period_end !== 1'b1 && len < 3000);
    ok = (period_end === 1'b1);
  endtask

  task automatic test_reset();
    do_reset(0, 1'b0);
    pol = 2'b01;
    wr(2'b01, 1'b1, 7'd50);
    wr(2'b01, 1'b1, 7'd20);
    repeat (20) @(negedge clk);
    n_cmp++; if (upd_pend !== 2'b01) begin n_bad++; $display("FAIL rst_pre_pend: got %b want 01", upd_pend); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pwm_o !== 2'b00) begin n_bad++; $display("FAIL rst_async_pwm: got %b want 00", pwm_o); end
    n_cmp++; if (upd_pend !== 2'b00) begin n_bad++; $display("FAIL rst_async_pend: got %b want 00", upd_pend); end
    repeat (2) @(negedge clk);
    n_cmp++; if (pwm_o !== 2'b00) begin n_bad++; $display("FAIL rst_hold_pwm: got %b want 00", pwm_o); end
    n_cmp++; if (period_end !== 1'b0) begin n_bad++; $display("FAIL rst_hold_pe: got %b want 0", period_end); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (pwm_o !== 2'b01) begin n_bad++; $display("FAIL rst_first_clk_pwm: got %b want 01", pwm_o); end
    n_cmp++; if (upd_pend !== 2'b00) begin n_bad++; $display("FAIL rst_first_clk_pend: got %b want 00", upd_pend); end
  endtask

  task automatic test_duty_extremes();
    int len, h0, h1;
    bit ok;
    do_reset(0, 1'b0);
    pol = 2'b00;
    wr(2'b01, 1'b1, 7'd0);
    wr(2'b10, 1'b1, 7'd127);
    wait_pe(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ext_wait_pe: got timeout want pulse"); end
    for (int p = 0; p < 3; p++) begin
      measure(len, h0, h1, ok);
      n_cmp++; if (len !== 128) begin n_bad++; $display("FAIL ext_len: got %0d want 128", len); end
      n_cmp++; if (h0 !== 0) begin n_bad++; $display("FAIL ext_duty0_high: got %0d want 0", h0); end
      n_cmp++; if (h1 !== 127) begin n_bad++; $display("FAIL ext_duty127_high: got %0d want 127", h1); end
    end
  endtask

  task automatic test_shadow();
    int len, h0, h1, h;
    bit ok;
    do_reset(0, 1'b0);
    pol = 2'b00;
    wr(2'b01, 1'b1, 7'd15);
    wait_pe(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sh_wait_pe: got timeout want pulse"); end
    h = 0;
    for (int c = 0; c < 30; c++) begin h += int'(pwm_o[0]); @(negedge clk); end
    wr_en = 2'b01; wr_ena = 1'b1; wr_duty = 7'd64;
    h += int'(pwm_o[0]);
    @(negedge clk);
    wr_en = '0;
    n_cmp++; if (upd_pend[0] !== 1'b1) begin n_bad++; $display("FAIL sh_pend_set: got %b want 1", upd_pend[0]); end
    measure(len, h0, h1, ok);
    h += h0;
    n_cmp++; if (h !== 15) begin n_bad++; $display("FAIL sh_cur_high: got %0d want 15", h); end
    n_cmp++; if (len + 31 !== 128) begin n_bad++; $display("FAIL sh_cur_len: got %0d want 128", len + 31); end
    n_cmp++; if (upd_pend[0] !== 1'b0) begin n_bad++; $display("FAIL sh_pend_clr: got %b want 0", upd_pend[0]); end
    measure(len, h0, h1, ok);
    n_cmp++; if (h0 !== 64) begin n_bad++; $display("FAIL sh_next_high: got %0d want 64", h0); end
  endtask

  task automatic test_boundary_write();
    int len, h0, h1, n;
    bit ok;
    wr(2'b01, 1'b1, 7'd15);
    n = 0;
    while (m_ph != lc_now() - 1 && n < 3000) begin @(negedge clk); n++; end
    wr_en = 2'b01; wr_ena = 1'b1; wr_duty = 7'd64;
    @(negedge clk);
    wr_en = '0;
    n_cmp++; if (upd_pend[0] !== 1'b0) begin n_bad++; $display("FAIL bw_pend: got %b want 0", upd_pend[0]); end
    wait_pe(ok);
    measure(len, h0, h1, ok);
    n_cmp++; if (h0 !== 64) begin n_bad++; $display("FAIL bw_high: got %0d want 64", h0); end
    repeat (10) @(negedge clk);
    n_cmp++; if (pwm_o[0] !== 1'b1) begin n_bad++; $display("FAIL dis_pre: got %b want 1", pwm_o[0]); end
    wr_en = 2'b01; wr_ena = 1'b0; wr_duty = 7'd64;
    @(negedge clk);
    wr_en = '0;
    n_cmp++; if (pwm_o[0] !== 1'b1) begin n_bad++; $display("FAIL dis_n1: got %b want 1", pwm_o[0]); end
    @(negedge clk);
    n_cmp++; if (pwm_o[0] !== 1'b0) begin n_bad++; $display("FAIL dis_n2: got %b want 0", pwm_o[0]); end
  endtask

  task automatic test_center();
    logic bits [0:1100];
    int len, h, len2, h0, h1;
    bit ok;
    do_reset(3, 1'b1);
    pol = 2'b00;
    wr(2'b01, 1'b1, 7'd64);
    wr(2'b10, 1'b1, 7'($urandom));
    wait_pe(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ctr_wait_pe: got timeout want pulse"); end
    len = 0; h = 0;
    do begin
      bits[len] = pwm_o[0]; h += int'(pwm_o[0]); len++;
      @(negedge clk);
    end while (period_end !== 1'b1 && len < 1100);
    n_cmp++; if (len !== 1024) begin n_bad++; $display("FAIL ctr_len: got %0d want 1024", len); end
    n_cmp++; if (h !== 512) begin n_bad++; $display("FAIL ctr_high: got %0d want 512", h); end
    n_cmp++; if (bits[0] !== 1'b1 || bits[255] !== 1'b1) begin n_bad++; $display("FAIL ctr_head: got %b%b want 11", bits[0], bits[255]); end
    n_cmp++; if (bits[256] !== 1'b0 || bits[767] !== 1'b0) begin n_bad++; $display("FAIL ctr_mid: got %b%b want 00", bits[256], bits[767]); end
    n_cmp++; if (bits[768] !== 1'b1 || bits[1023] !== 1'b1) begin n_bad++; $display("FAIL ctr_tail: got %b%b want 11", bits[768], bits[1023]); end
    measure(len2, h0, h1, ok);
    n_cmp++; if (len2 !== 1024) begin n_bad++; $display("FAIL ctr_len2: got %0d want 1024", len2); end
  endtask

  task automatic test_off();
    int bad, pes;
    bit ok;
    do_reset(0, 1'b0);
    pol = 2'b00;
    wr(2'b11, 1'b1, 7'd50);
    repeat (5) @(negedge clk);
    pol = 2'b10;
    wr(2'b11, 1'b0, 7'd0);
    repeat (3) @(negedge clk);
    wait_pe(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL off_wait_pe: got timeout want pulse"); end
    bad = 0; pes = 0;
    for (int c = 0; c < 5 * M; c++) begin
      if (pwm_o !== 2'b10) bad++;
      if (period_end === 1'b1) pes++;
      @(negedge clk);
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL off_hold: got %0d bad cycles want 0", bad); end
    n_cmp++; if (pes !== 5) begin n_bad++; $display("FAIL off_pe_count: got %0d want 5", pes); end
  endtask

  task automatic test_back_to_back();
    int len, h0, h1;
    bit ok;
    do_reset(0, 1'b0);
    pol = 2'b00;
    wr(2'b01, 1'b1, 7'd30);
    wait_pe(ok);
    repeat (20) @(negedge clk);
    wr(2'b01, 1'b1, 7'd100);
    wr(2'b01, 1'b1, 7'd40);
    n_cmp++; if (upd_pend[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_pend: got %b want 1", upd_pend[0]); end
    wait_pe(ok);
    measure(len, h0, h1, ok);
    n_cmp++; if (h0 !== 40) begin n_bad++; $display("FAIL b2b_high: got %0d want 40", h0); end
    n_cmp++; if (len !== 128) begin n_bad++; $display("FAIL b2b_len: got %0d want 128", len); end
  endtask

  task automatic test_random();
    pol = 2'($urandom);
    do_reset(1, 1'($urandom));
    for (int c = 0; c < 4000; c++) begin
      n_cmp++; if (pwm_o !== exp_pwm) begin n_bad++; $display("FAIL rnd_pwm @%0d: got %b want %b", c, pwm_o, exp_pwm); end
      n_cmp++; if (period_end !== exp_pe) begin n_bad++; $display("FAIL rnd_pe @%0d: got %b want %b", c, period_end, exp_pe); end
      n_cmp++; if (upd_pend !== exp_pend) begin n_bad++; $display("FAIL rnd_pend @%0d: got %b want %b", c, upd_pend, exp_pend); end
      wr_en  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr_ena = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       wr_duty = 7'd0;
        1:       wr_duty = 7'd127;
        default: wr_duty = 7'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) pol = 2'($urandom);
      if ($urandom_range(0, 999) == 0) mode = ~mode;
      @(negedge clk);
    end
    wr_en = '0;
  endtask

  initial begin
    rst = 1'b1; prescale = '0; mode = 1'b0; wr_en = '0; wr_ena = 1'b0; wr_duty = '0; pol = '0;
    @(negedge clk);
    test_reset();
    test_duty_extremes();
    test_shadow();
    test_boundary_write();
    test_center();
    test_off();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
